// File: rtl/fft8_frame_ctrl.sv
// fft8_frame_ctrl: collects 8-sample frames, runs them through the FFT core, and streams bins out.
// Define FFT8_FRAME_CNT_EN to add the 16-bit drained-frame counter output frame_cnt.
module fft8_frame_ctrl #(
    parameter int DW       = 16,
    parameter int CORE_LAT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_re,
    input  logic [DW-1:0]    in_im,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_re,
    output logic [DW-1:0]    out_im,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic [16*DW-1:0] core_x,
    output logic             core_mode,
    input  logic [16*DW-1:0] core_y,
`ifdef FFT8_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             busy
);

    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [CW-1:0] LAT_END = CW'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t        st;
    logic [CW-1:0] lat_cnt;
    logic [2:0]    wr_ptr;
    logic [2:0]    rd_ptr;
    logic          frame_mode;
    logic          ofull;

    logic [DW-1:0] ibuf_re [8];
    logic [DW-1:0] ibuf_im [8];
    logic [DW-1:0] obuf_re [8];
    logic [DW-1:0] obuf_im [8];

    logic in_fire;
    logic out_fire;
    logic cap_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = ofull && out_ready;
    // ofull is the registered flag, so a capture never overlaps the final drain beat
    assign cap_fire = (st == CAPTURE) && !ofull;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st       <= COLLECT;
            lat_cnt  <= '0;
            in_ready <= 1'b1;
        end else begin
            unique case (st)
                COLLECT: begin
                    if (in_fire && wr_ptr == 3'd7) begin
                        st       <= WAIT;
                        in_ready <= 1'b0;
                        lat_cnt  <= '0;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_END) begin
                        st      <= CAPTURE;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                CAPTURE: begin
                    if (!ofull) begin
                        st       <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    st       <= COLLECT;
                    in_ready <= 1'b1;
                    lat_cnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            frame_mode <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ibuf_re[i] <= '0;
                ibuf_im[i] <= '0;
            end
        end else if (in_fire) begin
            ibuf_re[wr_ptr] <= in_re;
            ibuf_im[wr_ptr] <= in_im;
            wr_ptr          <= wr_ptr + 3'd1;
            if (wr_ptr == 3'd0) begin
                frame_mode <= in_mode;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            ofull  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                obuf_re[i] <= '0;
                obuf_im[i] <= '0;
            end
        end else if (cap_fire) begin
            ofull <= 1'b1;
            for (int i = 0; i < 8; i++) begin
                obuf_re[i] <= core_y[2*i*DW +: DW];
                obuf_im[i] <= core_y[(2*i+1)*DW +: DW];
            end
        end else if (out_fire) begin
            rd_ptr <= rd_ptr + 3'd1;
            if (rd_ptr == 3'd7) begin
                ofull <= 1'b0;
            end
        end
    end

`ifdef FFT8_FRAME_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (out_fire && rd_ptr == 3'd7) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    for (genvar k = 0; k < 8; k++) begin : g_pack
        assign core_x[2*k*DW +: DW]     = ibuf_re[k];
        assign core_x[(2*k+1)*DW +: DW] = ibuf_im[k];
    end

    assign core_mode = frame_mode;
    assign out_valid = ofull;
    assign out_re    = obuf_re[rd_ptr];
    assign out_im    = obuf_im[rd_ptr];
    assign out_idx   = rd_ptr;
    assign out_last  = (rd_ptr == 3'd7);
    assign busy      = (wr_ptr != 3'd0) || (st != COLLECT) || ofull;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// tb_fft8_frame_ctrl: frame-level scoreboard bench for fft8_frame_ctrl.
// A behavioural 8-point DFT with two register stages stands in for the core.
module tb_fft8_frame_ctrl;

    localparam int DW = 16;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_re = '0;
    logic [DW-1:0]    in_im = '0;
    logic             in_mode = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    out_re;
    logic [DW-1:0]    out_im;
    logic [2:0]       out_idx;
    logic             out_last;
    logic [16*DW-1:0] core_x;
    logic             core_mode;
    logic [16*DW-1:0] core_y = '0;
    logic [16*DW-1:0] core_s1 = '0;
    logic             busy;
`ifdef FFT8_FRAME_CNT_EN
    logic [15:0]      frame_cnt;
`endif

    always #5 clk = ~clk;

    fft8_frame_ctrl #(.DW(DW), .CORE_LAT(LAT)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_re(in_re),
        .in_im(in_im),
        .in_mode(in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re(out_re),
        .out_im(out_im),
        .out_idx(out_idx),
        .out_last(out_last),
        .core_x(core_x),
        .core_mode(core_mode),
        .core_y(core_y),
`ifdef FFT8_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .busy(busy)
    );

    function automatic logic [16*DW-1:0] dft8(input logic [16*DW-1:0] x, input logic m);
        logic [16*DW-1:0] y;
        real sr, si, a, xr, xi;
        int t;
        logic [31:0] tv;
        y = '0;
        for (int k = 0; k < 8; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < 8; n++) begin
                xr = real'($signed(x[2*n*DW +: DW]));
                xi = real'($signed(x[(2*n+1)*DW +: DW]));
                a = (m ? 1.0 : -1.0) * 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
                sr = sr + xr * $cos(a) - xi * $sin(a);
                si = si + xr * $sin(a) + xi * $cos(a);
            end
            if (m) begin
                sr = sr / 8.0;
                si = si / 8.0;
            end
            t = int'(sr);
            tv = t;
            y[2*k*DW +: DW] = tv[DW-1:0];
            t = int'(si);
            tv = t;
            y[(2*k+1)*DW +: DW] = tv[DW-1:0];
        end
        return y;
    endfunction

    always @(posedge clk) begin
        core_s1 <= dft8(core_x, core_mode);
        core_y  <= core_s1;
    end

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    idx;
        logic          last;
    } oexp_t;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          mode;
    } beat_t;

    oexp_t         exp_q[$];
    beat_t         send_q[$];
    logic [DW-1:0] acc_re[$];
    logic [DW-1:0] acc_im[$];
    logic          acc_mode = 1'b0;
    logic          mode_exp = 1'b0;
    int            v0_steps[$];
    logic          v0_prev = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_done = 0;
    int n_out = 0;
    int consumed = 0;
    int stop_at = 0;
    int sink_pol = 0;
    int gap_pct = 0;
    int t_first_acc = -1;
    int t_first_v = -1;

    function automatic logic [DW-1:0] rnd_s();
        int v;
        logic [31:0] t;
        v = int'($urandom_range(4000)) - 2000;
        t = v;
        return t[DW-1:0];
    endfunction

    task automatic clear_model();
        exp_q.delete();
        send_q.delete();
        acc_re.delete();
        acc_im.delete();
        v0_prev = 1'b0;
    endtask

    task automatic accept_beat(input beat_t b);
        logic [16*DW-1:0] x;
        logic [16*DW-1:0] y;
        oexp_t e;
        if (acc_re.size() == 0) acc_mode = b.mode;
        acc_re.push_back(b.re);
        acc_im.push_back(b.im);
        if (acc_re.size() == 8) begin
            x = '0;
            for (int n = 0; n < 8; n++) begin
                x[2*n*DW +: DW]     = acc_re[n];
                x[(2*n+1)*DW +: DW] = acc_im[n];
            end
            y = dft8(x, acc_mode);
            for (int k = 0; k < 8; k++) begin
                e.re   = y[2*k*DW +: DW];
                e.im   = y[(2*k+1)*DW +: DW];
                e.idx  = k[2:0];
                e.last = (k == 7);
                exp_q.push_back(e);
            end
            mode_exp = acc_mode;
            frames_done++;
            acc_re.delete();
            acc_im.delete();
        end
    endtask

    task automatic queue_frame(input logic m, input int kind, input logic [DW-1:0] amp);
        beat_t b;
        logic [31:0] r;
        for (int n = 0; n < 8; n++) begin
            r = $urandom;
            case (kind)
                0: b.re = (n == 0) ? amp : '0;
                1: b.re = amp;
                default: b.re = rnd_s();
            endcase
            b.im = (kind == 2) ? rnd_s() : '0;
            b.mode = (n == 0) ? m : r[0];
            send_q.push_back(b);
        end
    endtask

    task automatic step();
        beat_t b;
        logic [31:0] r;
        @(negedge clk);
        cyc++;
        case (sink_pol)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(99) < 60);
            default: out_ready = (consumed < stop_at);
        endcase
        if (out_valid) begin
            if (out_idx == 3'd0 && !v0_prev) v0_steps.push_back(cyc);
            if (t_first_v < 0) t_first_v = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got idx=%0d re=%h im=%h want no output",
                         out_idx, out_re, out_im);
            end else if ({out_re, out_im, out_idx, out_last} !==
                         {exp_q[0].re, exp_q[0].im, exp_q[0].idx, exp_q[0].last}) begin
                errors++;
                $display("FAIL out_sample got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                         out_re, out_im, out_idx, out_last,
                         exp_q[0].re, exp_q[0].im, exp_q[0].idx, exp_q[0].last);
            end
            if (out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                consumed++;
                n_out++;
            end
        end
        v0_prev = out_valid && (out_idx == 3'd0);
        if (!in_ready) begin
            checks++;
            if (core_mode !== mode_exp) begin
                errors++;
                $display("FAIL core_mode_hold got %b want %b", core_mode, mode_exp);
            end
        end
        if (send_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            in_valid = 1'b1;
            in_re    = send_q[0].re;
            in_im    = send_q[0].im;
            in_mode  = send_q[0].mode;
        end else begin
            r = $urandom;
            in_valid = 1'b0;
            in_re    = r[15:0];
            in_im    = r[31:16];
            in_mode  = r[3];
        end
        if (in_valid && in_ready) begin
            b = send_q.pop_front();
            if (t_first_acc < 0) t_first_acc = cyc;
            accept_beat(b);
        end
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((send_q.size() > 0 || exp_q.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout got %0d cycles pending_out=%0d want idle within %0d",
                     name, n, exp_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        clear_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        if (out_idx !== 3'd0) begin errors++; $display("FAIL rst_out_idx got %0d want 0", out_idx); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
        if (core_mode !== 1'b0) begin errors++; $display("FAIL rst_core_mode got %b want 0", core_mode); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        if (core_x !== '0) begin errors++; $display("FAIL rst_core_x got %h want 0", core_x); end
    endtask

    task automatic test_impulse();
        int n0;
        sink_pol = 0;
        gap_pct = 0;
        t_first_acc = -1;
        t_first_v = -1;
        n0 = n_out;
        queue_frame(1'b0, 0, 16'h0100);
        run_until_idle(100, "impulse");
        checks += 2;
        if (t_first_v - t_first_acc != 8 + LAT + 1) begin
            errors++;
            $display("FAIL impulse_latency got %0d want %0d", t_first_v - t_first_acc, 8 + LAT + 1);
        end
        if (n_out - n0 != 8) begin
            errors++;
            $display("FAIL impulse_count got %0d want 8", n_out - n0);
        end
    endtask

    task automatic test_dc();
        sink_pol = 0;
        gap_pct = 0;
        queue_frame(1'b0, 1, 16'h0010);
        run_until_idle(100, "dc");
    endtask

    task automatic test_inverse();
        sink_pol = 0;
        gap_pct = 0;
        queue_frame(1'b1, 0, 16'h0400);
        run_until_idle(100, "inverse");
    endtask

    task automatic test_back_to_back();
        sink_pol = 0;
        gap_pct = 0;
        v0_steps.delete();
        for (int f = 0; f < 3; f++) queue_frame(f[0], 2, '0);
        run_until_idle(200, "b2b");
        checks++;
        if (v0_steps.size() != 3) begin
            errors++;
            $display("FAIL b2b_frames got %0d want 3", v0_steps.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (v0_steps[i] - v0_steps[i-1] != 8 + LAT + 1) begin
                    errors++;
                    $display("FAIL b2b_period got %0d want %0d",
                             v0_steps[i] - v0_steps[i-1], 8 + LAT + 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        sink_pol = 3;
        consumed = 0;
        stop_at = 2;
        gap_pct = 0;
        queue_frame(1'b0, 2, '0);
        queue_frame(1'b1, 2, '0);
        for (int i = 0; i < 40; i++) step();
        checks += 5;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
        if (out_idx !== 3'd2) begin errors++; $display("FAIL bp_out_idx got %0d want 2", out_idx); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b want 1", busy); end
        if (frames_done < 2 || send_q.size() != 0) begin
            errors++;
            $display("FAIL bp_second_frame got pending_beats=%0d want 0", send_q.size());
        end
        sink_pol = 0;
        run_until_idle(100, "bp_release");
    endtask

    task automatic test_random();
        sink_pol = 1;
        gap_pct = 30;
        for (int f = 0; f < 6; f++) queue_frame($urandom_range(1), 2, '0);
        run_until_idle(2000, "random");
    endtask

    task automatic test_reset_mid_wait();
        int f0;
        int n;
        sink_pol = 0;
        gap_pct = 0;
        f0 = frames_done;
        n = 0;
        queue_frame(1'b1, 2, '0);
        while (frames_done == f0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (frames_done == f0) begin
            errors++;
            $display("FAIL rmw_collect got %0d beats pending want 0", send_q.size());
        end
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        clear_model();
        @(negedge clk);
        checks += 3;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmw_in_ready got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmw_out_valid got %b want 0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rmw_busy got %b want 0", busy); end
        reset = 1'b0;
        queue_frame(1'b0, 0, 16'h0100);
        run_until_idle(100, "rmw_fresh");
    endtask

    task automatic test_frame_cnt();
`ifdef FFT8_FRAME_CNT_EN
        do_reset();
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL fcnt_reset got %0d want 0", frame_cnt); end
        sink_pol = 1;
        gap_pct = 10;
        for (int f = 0; f < 3; f++) queue_frame(1'b0, 2, '0);
        run_until_idle(500, "fcnt");
        checks++;
        if (frame_cnt !== 16'd3) begin errors++; $display("FAIL fcnt_three got %0d want 3", frame_cnt); end
        do_reset();
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL fcnt_clear got %0d want 0", frame_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_inverse();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        test_frame_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft8_frame_ctrl.md
Name: fft8_frame_ctrl

Overview:
- Frame sequencer for the 8-point radix-2 DIT FFT core (16-bit signed complex, forward/inverse via `mode`).
- Collects a streaming complex input, one sample per beat, into an 8-entry input buffer, then presents the full frame and a held `mode` to the core.
- Waits out the core's register latency, captures the 8 results, and streams them out in natural bin order (k=0..7) under valid/ready.
- Input and output buffers are independent, so the next frame can be collected while the current one drains.

Parameters:
- DW, 16, sample component width (real and imag each); must match the core.
- CORE_LAT, 2, cycles from `core_x`/`core_mode` stable to `core_y` valid.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  input sample valid.
- in_ready  output  1  controller can accept a sample.
- in_re  input  DW  input real part, signed.
- in_im  input  DW  input imag part, signed.
- in_mode  input  1  0=FFT, 1=IFFT; sampled on the first accepted beat of each frame.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts the sample.
- out_re  output  DW  result real part.
- out_im  output  DW  result imag part.
- out_idx  output  3  bin index of the current output sample.
- out_last  output  1  high with bin 7.
- core_x  output  16*DW  frame to core; sample k real at [2k*DW +: DW], imag at [(2k+1)*DW +: DW].
- core_mode  output  1  mode to core; held for the whole compute.
- core_y  input  16*DW  core result, same packing as `core_x`.
- busy  output  1  any buffer non-empty or compute in progress.

Behaviour:
- Reset values:
  - all buffers 0; `wr_ptr` = 0; `rd_ptr` = 0.
  - compute FSM in COLLECT.
  - `in_ready` = 1, `out_valid` = 0, `out_idx` = 0, `out_last` = 0, `core_mode` = 0, `busy` = 0.
- Reset asserted in any state aborts the frame immediately; partial input and undrained output are discarded.
- Input side:
  - A beat is accepted when `in_valid` && `in_ready`; the sample is written to `ibuf[wr_ptr]` and `wr_ptr` increments.
  - On `wr_ptr` = 0, `in_mode` is latched into `frame_mode`.
  - On the 8th beat, `wr_ptr` wraps to 0 and the FSM moves to WAIT.
- `core_x` is driven continuously from `ibuf`. `core_mode` is driven from `frame_mode`.
- Compute FSM:
  - COLLECT: `in_ready` = 1. Exit to WAIT on acceptance of the 8th beat.
  - WAIT: `in_ready` = 0; `ibuf` and `frame_mode` frozen; counter runs 0..CORE_LAT-1. After CORE_LAT cycles, go to CAPTURE.
  - CAPTURE: `in_ready` = 0. If the output buffer is empty, load `obuf` from `core_y`, set `ofull`, go to COLLECT. Otherwise stay; inputs are still frozen, so `core_y` remains valid.
- Output side:
  - `out_valid` = `ofull`.
  - `out_re`/`out_im` = `obuf[rd_ptr]`; `out_idx` = `rd_ptr`; `out_last` = (`rd_ptr` == 7).
  - On `out_valid` && `out_ready`, `rd_ptr` increments. At 7, it wraps to 0 and clears `ofull`.
- Simultaneous events:
  - Drain completion and CAPTURE in the same cycle: CAPTURE waits one cycle, because it checks the registered `ofull`.
  - Input accept during drain is allowed in COLLECT.
- No arithmetic on data; the controller only stores and forwards. Scaling (IFFT >>>3) is done by the core.
- Latency, with continuous input and `out_ready` = 1:
  - first input beat at cycle 0 → `out_valid` with bin 0 at cycle 8+CORE_LAT+1 (cycle 11 at default CORE_LAT).
  - sustained rate: 8 samples per 8+CORE_LAT+1 cycles.
- `busy` = (`wr_ptr` != 0) || state != COLLECT || `ofull`.

Optional Feature:
- Macro FFT8_FRAME_CNT_EN.
- Defined: adds output `frame_cnt` (16 bits, reset 0). It increments on the `out_last` handshake and wraps 0xFFFF→0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Impulse, forward: `in_mode`=0, sample 0 = (0x0100,0), samples 1..7 = 0 → 8 outputs, each (0x0100,0x0000); `out_idx` 0..7; `out_last` only on idx 7; first `out_valid` at cycle 11.
- DC, forward: all 8 samples (0x0010,0) → bin0 (0x0080,0); bins 1..7 (0,0).
- Inverse: `in_mode`=1, sample 0 = (0x0400,0), others 0 → all 8 outputs (0x0080,0). `core_mode` held 1 throughout WAIT/CAPTURE.
- Backpressure:
  - Setup: `out_ready`=0 after bin 2, with a second frame streamed in.
  - Outputs hold at bin 2.
  - Second frame: collected, then stalls in CAPTURE with `in_ready`=0.
  - Release `out_ready`: remaining bins 2..7 emerge, followed by frame 2 intact.
- Reset mid-WAIT: assert `reset` one cycle after the 8th beat → `in_ready`=1, `out_valid`=0, `busy`=0 next cycle. A fresh impulse frame then produces correct results.
- FFT8_FRAME_CNT_EN: drain 3 frames → `frame_cnt` = 3; reset → 0.
